// File: rtl/knn_topk_pipe_if.sv
// knn_topk_pipe_if: training-sample stream in, ranked neighbour read-out.
interface knn_topk_pipe_if #(
   parameter int W    = 16,
   parameter int K    = 10,
   parameter int IDXW = 8,
   parameter int LW   = 4
);
   logic                     start;
   logic                     valid;
   logic                     last;
   logic signed [W-1:0]      x1, y1, x2, y2;
   logic [LW-1:0]            label_in;
   logic [$clog2(K)-1:0]     sel;
   logic [2*W+2:0]           dist_out;
   logic [IDXW-1:0]          idx_out;
   logic [LW-1:0]            label_out;
   logic [$clog2(K+1)-1:0]   count;
   logic                     done;
   logic                     ovf;

   modport master (
      output start, valid, last, x1, y1, x2, y2, label_in, sel,
      input  dist_out, idx_out, label_out, count, done, ovf
   );

   modport slave (
      input  start, valid, last, x1, y1, x2, y2, label_in, sel,
      output dist_out, idx_out, label_out, count, done, ovf
   );
endinterface

// File: rtl/knn_topk_pipe.sv
// knn_topk_pipe: 3-stage squared-distance pipe feeding a parallel top-K sorter.
// Define KNN_LABEL_EN to store class labels alongside each ranked entry.
module knn_topk_pipe #(
   parameter int W    = 16,
   parameter int K    = 10,
   parameter int IDXW = 8,
   parameter int LW   = 4
) (
   input  logic           clk,
   input  logic           rst,
   knn_topk_pipe_if.slave bus
);
   localparam int DW = 2*W+3;
   localparam int SW = $clog2(K);
   localparam int CW = $clog2(K+1);

   logic signed [W:0]     dx, dy, dx_q, dy_q;
   logic signed [2*W+1:0] dx_e, dy_e;
   logic [2*W+1:0]        sx_q, sy_q;
   logic [DW-1:0]         d_q;
   logic [2:0]            v_p, l_p;
   logic [IDXW-1:0]       i_p [3];
   logic [IDXW-1:0]       idx_cnt, tag;
   logic                  accept;

   logic [DW-1:0]         dist_r    [K];
   logic [IDXW-1:0]       idx_r     [K];
   logic [DW-1:0]         prev_dist [K];
   logic [IDXW-1:0]       prev_idx  [K];
   logic [K-1:0]          occ, ins, first;
   logic [2**SW-1:0]      occ_x;
   logic [CW-1:0]         cnt;
   logic                  done_q, ovf_q, hit;

   assign accept = bus.valid && (bus.start || !done_q);
   assign tag    = bus.start ? '0 : idx_cnt;

   assign dx   = {bus.x1[W-1], bus.x1} - {bus.x2[W-1], bus.x2};
   assign dy   = {bus.y1[W-1], bus.y1} - {bus.y2[W-1], bus.y2};
   assign dx_e = {{(W+1){dx_q[W]}}, dx_q};
   assign dy_e = {{(W+1){dy_q[W]}}, dy_q};

   // Entries stay sorted with empties at the bottom, so ins is a thermometer.
   always_comb begin
      for (int r = 0; r < K; r++)
         ins[r] = !occ[r] || (dist_r[r] > d_q);
      first        = ins & ~{ins[K-2:0], 1'b0};
      prev_dist[0] = '1;
      prev_idx[0]  = '0;
      for (int r = 1; r < K; r++) begin
         prev_dist[r] = dist_r[r-1];
         prev_idx[r]  = idx_r[r-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dx_q    <= '0;
         dy_q    <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         d_q     <= '0;
         v_p     <= '0;
         l_p     <= '0;
         i_p     <= '{default: '0};
         idx_cnt <= '0;
         cnt     <= '0;
         occ     <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dist_r  <= '{default: '1};
         idx_r   <= '{default: '0};
      end else begin
         dx_q   <= dx;
         dy_q   <= dy;
         sx_q   <= $unsigned(dx_e * dx_e);
         sy_q   <= $unsigned(dy_e * dy_e);
         d_q    <= {1'b0, sx_q} + {1'b0, sy_q};
         v_p    <= {v_p[1:0] & {2{~bus.start}}, accept};
         l_p    <= {l_p[1:0], bus.last};
         i_p[0] <= tag;
         i_p[1] <= i_p[0];
         i_p[2] <= i_p[1];
         if (bus.start) begin
            occ    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            dist_r <= '{default: '1};
            idx_r  <= '{default: '0};
         end else if (v_p[2]) begin
            for (int r = 0; r < K; r++) begin
               if (first[r]) begin
                  dist_r[r] <= d_q;
                  idx_r[r]  <= i_p[2];
               end else if (ins[r]) begin
                  dist_r[r] <= prev_dist[r];
                  idx_r[r]  <= prev_idx[r];
               end
            end
            occ <= {occ[K-2:0], 1'b1};
            if (cnt != CW'(K))
               cnt <= cnt + 1'b1;
            if (l_p[2])
               done_q <= 1'b1;
         end
         if (accept) begin
            idx_cnt <= tag + 1'b1;
            if (&tag)
               ovf_q <= 1'b1;
         end else if (bus.start) begin
            idx_cnt <= '0;
         end
      end
   end

   always_comb begin
      occ_x        = '0;
      occ_x[K-1:0] = occ;
   end

   assign hit          = occ_x[bus.sel];
   assign bus.dist_out = hit ? dist_r[bus.sel] : '1;
   assign bus.idx_out  = hit ? idx_r[bus.sel] : '0;
   assign bus.count    = cnt;
   assign bus.done     = done_q;
   assign bus.ovf      = ovf_q;

`ifdef KNN_LABEL_EN
   logic [LW-1:0] lb_p     [3];
   logic [LW-1:0] lab_r    [K];
   logic [LW-1:0] prev_lab [K];

   always_comb begin
      prev_lab[0] = '0;
      for (int r = 1; r < K; r++)
         prev_lab[r] = lab_r[r-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lb_p  <= '{default: '0};
         lab_r <= '{default: '0};
      end else begin
         lb_p[0] <= bus.label_in;
         lb_p[1] <= lb_p[0];
         lb_p[2] <= lb_p[1];
         if (bus.start) begin
            lab_r <= '{default: '0};
         end else if (v_p[2]) begin
            for (int r = 0; r < K; r++) begin
               if (first[r])
                  lab_r[r] <= lb_p[2];
               else if (ins[r])
                  lab_r[r] <= prev_lab[r];
            end
         end
      end
   end

   assign bus.label_out = hit ? lab_r[bus.sel] : '0;
`else
   assign bus.label_out = '0;
`endif
endmodule

// File: tb/tb_knn_topk_pipe.sv
// tb_knn_topk_pipe: random and directed runs against a sort-based reference
// model; a second small instance exercises index-counter wrap.
module tb_knn_topk_pipe;
   localparam int W    = 16;
   localparam int K    = 10;
   localparam int IDXW = 8;
   localparam int LW   = 4;
   localparam int DW   = 2*W+3;
   localparam longint ONES  = (longint'(1) << DW) - 1;
   localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   longint m_d[$];
   longint m_v[$];
   int     m_i[$];
   int     m_l[$];
   int     m_cnt = 0;
   bit     m_ovf = 1'b0;
   longint done_vis = NEVER;

   knn_topk_pipe_if #(.W(W), .K(K), .IDXW(IDXW), .LW(LW)) bus ();
   knn_topk_pipe_if #(.W(W), .K(4), .IDXW(2), .LW(LW)) bus2 ();

   knn_topk_pipe #(.W(W), .K(K), .IDXW(IDXW), .LW(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   knn_topk_pipe #(.W(W), .K(4), .IDXW(2), .LW(LW)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", n, act, exp);
      end
   endtask

   task automatic clear();
      m_d.delete();
      m_v.delete();
      m_i.delete();
      m_l.delete();
      m_cnt    = 0;
      m_ovf    = 1'b0;
      done_vis = NEVER;
   endtask

   // Reference: record every accepted sample with the cycle it becomes visible.
   task automatic model_update();
      bit     dn;
      longint ddx, ddy;
      if (rst) begin
         clear();
         return;
      end
      dn = (done_vis <= cyc - 1);
      if (bus.start)
         clear();
      if (bus.valid && (bus.start || !dn)) begin
         ddx = longint'(bus.x1) - longint'(bus.x2);
         ddy = longint'(bus.y1) - longint'(bus.y2);
         m_d.push_back(ddx*ddx + ddy*ddy);
         m_v.push_back(cyc + 3);
         m_i.push_back(m_cnt);
         m_l.push_back(int'(bus.label_in));
         if (bus.last)
            done_vis = cyc + 3;
         if (m_cnt == (1 << IDXW) - 1) begin
            m_ovf = 1'b1;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_update();
      #1;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) begin
         bus.valid = 1'b0;
         bus.last  = 1'b0;
         bus.sel   = 4'($urandom);
         tick();
      end
   endtask

   task automatic sample(int x, int y, bit lst);
      bus.valid    = 1'b1;
      bus.x2       = 16'(x);
      bus.y2       = 16'(y);
      bus.last     = lst;
      bus.label_in = 4'($urandom);
      bus.sel      = 4'($urandom);
      tick();
      bus.valid = 1'b0;
      bus.last  = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic sweep();
      for (int s = 0; s < 16; s++) begin
         bus.sel = 4'(s);
         tick();
      end
   endtask

   task automatic lit(string n, int s, longint d, int i);
      bus.sel = 4'(s);
      #1;
      chk({n, " dist"}, bus.dist_out, d);
      chk({n, " idx"}, longint'(bus.idx_out), longint'(i));
      tick();
   endtask

   function automatic logic signed [15:0] pick();
      int c;
      c = $urandom_range(0, 3);
      if (c == 0) return 16'sh8000;
      if (c == 1) return 16'sh7fff;
      return 16'($urandom);
   endfunction

   // Rank of sample j = visible samples strictly closer, or equal and earlier.
   always @(negedge clk) begin
      int     nv, rk, s, ei, el;
      longint ed;
      s  = int'(bus.sel);
      nv = 0;
      ed = ONES;
      ei = 0;
      el = 0;
      for (int j = 0; j < m_d.size(); j++) begin
         if (m_v[j] > cyc) continue;
         nv++;
         rk = 0;
         for (int i = 0; i < m_d.size(); i++)
            if (m_v[i] <= cyc &&
                (m_d[i] < m_d[j] || (m_d[i] == m_d[j] && i < j)))
               rk++;
         if (rk == s && rk < K) begin
            ed = m_d[j];
            ei = m_i[j];
`ifdef KNN_LABEL_EN
            el = m_l[j];
`endif
         end
      end
      chk("count", longint'(bus.count), longint'(nv < K ? nv : K));
      chk("done", longint'(bus.done), longint'(done_vis <= cyc));
      chk("ovf", longint'(bus.ovf), longint'(m_ovf));
      chk("dist_out", bus.dist_out, ed);
      chk("idx_out", longint'(bus.idx_out), longint'(ei));
      chk("label_out", longint'(bus.label_out), longint'(el));
   end

   initial begin
      int xs [5];
      int n;
      xs = '{2, 3, 4, 5, 1};
      bus.start = 0; bus.valid = 0; bus.last = 0; bus.sel = 0;
      bus.x1 = 0; bus.y1 = 0; bus.x2 = 0; bus.y2 = 0; bus.label_in = 0;
      bus2.start = 0; bus2.valid = 0; bus2.last = 0; bus2.sel = 0;
      bus2.x1 = 0; bus2.y1 = 0; bus2.x2 = 0; bus2.y2 = 0; bus2.label_in = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset count", longint'(bus.count), 0);
      chk("reset done", longint'(bus.done), 0);
      chk("reset dist", bus.dist_out, ONES);

      // Basic run from the origin.
      pulse_start();
      sample(3, 4, 0);
      sample(1, 1, 0);
      sample(0, 2, 1);
      tick();
      tick();
      chk("done before t+4", longint'(bus.done), 0);
      tick();
      chk("done at t+4", longint'(bus.done), 1);
      chk("count3", longint'(bus.count), 3);
      lit("r0", 0, 2, 1);
      lit("r1", 1, 4, 2);
      lit("r2", 2, 25, 0);
      lit("r3 empty", 3, ONES, 0);
      lit("sel oob", 12, ONES, 0);

      // Valid while done must be dropped.
      sample(0, 0, 0);
      idle(5);
      chk("ignored count", longint'(bus.count), 3);
      lit("ignored r0", 0, 2, 1);

      // Tie: equal distance keeps earlier sample first; start+valid is idx 0.
      bus.start = 1'b1;
      sample(1, 2, 0);
      bus.start = 1'b0;
      sample(2, 1, 1);
      idle(4);
      lit("tie r0", 0, 5, 0);
      lit("tie r1", 1, 5, 1);

      // Start two cycles after a sample kills it.
      pulse_start();
      sample(0, 3, 0);
      idle(1);
      bus.start = 1'b1;
      sample(1, 0, 0);
      bus.start = 1'b0;
      idle(5);
      chk("restart count", longint'(bus.count), 1);
      chk("restart done", longint'(bus.done), 0);
      lit("restart r0", 0, 1, 0);
      lit("restart r1", 1, ONES, 0);

      // Largest representable distance.
      bus.x1 = 16'sh7fff;
      bus.y1 = 16'sh7fff;
      pulse_start();
      sample(-32768, -32768, 1);
      idle(4);
      lit("max dist", 0, 64'd8589672450, 0);

      // 20 back-to-back samples with coordinate extremes.
      bus.x1 = pick();
      bus.y1 = pick();
      pulse_start();
      for (int k = 0; k < 20; k++)
         sample(int'(pick()), int'(pick()), k == 19);
      idle(4);
      chk("rand20 count", longint'(bus.count), 10);
      sweep();

      // Random runs with gaps.
      for (int r = 0; r < 3; r++) begin
         bus.x1 = pick();
         bus.y1 = pick();
         pulse_start();
         n = $urandom_range(2, 24);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0)
               idle(1);
            sample(int'(pick()), int'(pick()), k == n - 1);
         end
         idle(4);
         sweep();
         sample(int'(pick()), int'(pick()), 0);
         idle(4);
      end

      // Asynchronous reset with three samples in flight.
      bus.x1 = 0;
      bus.y1 = 0;
      pulse_start();
      for (int k = 0; k < 5; k++)
         sample(k + 1, k, 0);
      bus.sel = 0;
      #2;
      rst = 1'b1;
      clear();
      #1;
      chk("async rst count", longint'(bus.count), 0);
      chk("async rst dist", bus.dist_out, ONES);
      chk("async rst idx", longint'(bus.idx_out), 0);
      chk("async rst done", longint'(bus.done), 0);
      tick();
      rst = 1'b0;
      idle(6);
      chk("post rst count", longint'(bus.count), 0);

      // Index wrap on the IDXW=2 instance.
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus2.valid = 1'b1;
         bus2.x2    = 16'(xs[k]);
         tick();
      end
      bus2.valid = 1'b0;
      chk("ovf2 set", longint'(bus2.ovf), 1);
      idle(4);
      bus2.sel = 2'd0;
      #1;
      chk("wrap r0 dist", bus2.dist_out, 1);
      chk("wrap r0 idx", longint'(bus2.idx_out), 0);
      bus2.sel = 2'd1;
      #1;
      chk("wrap r1 idx", longint'(bus2.idx_out), 0);
      bus2.sel = 2'd3;
      #1;
      chk("wrap r3 dist", bus2.dist_out, 16);
      chk("wrap count", longint'(bus2.count), 4);
      tick();
      chk("ovf2 held", longint'(bus2.ovf), 1);
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      chk("ovf2 cleared", longint'(bus2.ovf), 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/knn_topk_pipe.md
KNN_TOPK_PIPE -- requirements
Module: knn_topk_pipe

Interface
REQ-001 The block SHALL have these parameters: W, 16, signed coordinate width; K, 10, neighbours kept (2..16); IDXW, 8, sample-index width; LW, 4, label width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  one-cycle pulse: clear list, index counter, done, ovf; flush pipeline.
REQ-005 valid  in  1  one training sample presented this cycle.
REQ-006 last  in  1  qualifies valid: final sample of the run.
REQ-007 x1, y1  in  W each  signed test-point coordinates, held stable for the run.
REQ-008 x2, y2  in  W each  signed training-point coordinates.
REQ-009 label_in  in  LW  class label of the training point.
REQ-010 sel  in  $clog2(K)  rank select, 0 = nearest.
REQ-011 dist_out  out  2W+3  squared distance at rank sel.
REQ-012 idx_out  out  IDXW  sample index at rank sel.
REQ-013 label_out  out  LW  label at rank sel.
REQ-014 count  out  $clog2(K+1)  occupied entries, saturating at K.
REQ-015 done  out  1  level: list final for this run.
REQ-016 ovf  out  1  sticky: index counter wrapped during this run.

Function
REQ-017 The distance path SHALL be 3 registered stages: dx=x1-x2, dy=y1-y2 (W+1 signed); dx*dx, dy*dy (2W+2 unsigned); sum (2W+3), with no truncation.
REQ-018 An accepted valid SHALL be tagged with the current index counter and label_in; the counter SHALL then increment, wrapping from 2^IDXW-1 to 0 and setting ovf.
REQ-019 Index, label, valid and last SHALL be delayed alongside the distance so all four reach the sorter together.
REQ-020 The sorter SHALL compare the new distance with all K entries in parallel in the 4th cycle and insert at the first rank whose entry is empty or has a strictly greater distance; lower-ranked entries SHALL shift down one and the rank-K entry is dropped.
REQ-021 Ties SHALL keep the earlier sample at the better rank.
REQ-022 A sample presented with valid at cycle t SHALL be visible on the outputs from cycle t+4; throughput SHALL be one sample per cycle with no stalls.
REQ-023 done SHALL rise at t+4 for the sample flagged last at t and hold until start or rst.
REQ-024 valid while done=1 SHALL be ignored.
REQ-025 start SHALL kill all in-flight samples; a valid in the same cycle as start SHALL be accepted as index 0 of the new run.
REQ-026 Outputs SHALL be combinational reads of rank sel; sel>=K or an empty rank SHALL give dist_out all-ones and idx_out=0, label_out=0.
REQ-027 count SHALL increment on each insertion while below K.

Reset
REQ-028 rst SHALL clear the pipeline valids, the index counter, count, done and ovf, and mark all entries empty with distance all-ones.
REQ-029 rst mid-run SHALL discard all in-flight samples with no later insertion.

Configuration
REQ-030 With KNN_LABEL_EN defined, labels SHALL be stored and carried as specified; without it, label_in SHALL be ignored, no label storage SHALL exist, and label_out SHALL be tied to 0.

Verification
REQ-031 Test (0,0); samples (3,4),(1,1),(0,2), last on the 3rd -> rank0 d=2 idx1, rank1 d=4 idx2, rank2 d=25 idx0; done 4 cycles after last; count=3.
REQ-032 K=10; 20 back-to-back random samples with W=16 extremes (-32768 vs 32767) -> ranks match the sorted software model; d=2*65535^2 is exact; count=10.
REQ-033 Two samples at equal distance 5, idx 0 then 1 -> idx0 at rank0, idx1 at rank1.
REQ-034 Issue start 2 cycles after a valid sample, then a new sample with start -> the first-run sample never appears; the new sample has idx 0; done=0.
REQ-035 IDXW=2; 5 samples -> 5th tagged idx 0; ovf=1 until start.
REQ-036 Assert rst asynchronously mid-run with 3 in flight -> all outputs at reset values immediately; nothing inserted afterwards; with KNN_LABEL_EN, label_out tracks label_in per rank.
